// File: rtl/pulse_freq_meter_if.sv
// Purpose: control/report bundle for pulse_freq_meter (enable + tick in, report out).
// Latency: n/a (signal bundle only).
// Backpressure: none; the report is a one-cycle strobe with held data.
// Ports: enable, tick_in (master -> slave); freq_hz, freq_valid, overflow, busy (slave -> master).
interface pulse_freq_meter_if #(
  parameter int unsigned WIDTH = 26
);
  logic             enable;
  logic             tick_in;
  logic [WIDTH-1:0] freq_hz;
  logic             freq_valid;
  logic             overflow;
  logic             busy;

  modport master (
    output enable,
    output tick_in,
    input  freq_hz,
    input  freq_valid,
    input  overflow,
    input  busy
  );

  modport slave (
    input  enable,
    input  tick_in,
    output freq_hz,
    output freq_valid,
    output overflow,
    output busy
  );
endinterface

// File: rtl/pulse_freq_meter.sv
// Purpose: counts rising edges of tick_in over back-to-back GATE_CYCLES windows.
// Latency: report strobes GATE_CYCLES+1 clocks after enable is first sampled high, then every GATE_CYCLES.
// Backpressure: none; freq_valid is a single-cycle strobe, freq_hz/overflow hold until the next report.
// Ports: clk, rst (sync, active-high); bus.enable, bus.tick_in in;
//        bus.freq_hz, bus.freq_valid, bus.overflow, bus.busy out (all registered).
module pulse_freq_meter #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned WIDTH       = 26
) (
  input  logic              clk,
  input  logic              rst,
  pulse_freq_meter_if.slave bus
);

  localparam int unsigned      GW         = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [0:0]       state;
  logic [GW-1:0]    gate_cnt;
  logic [WIDTH-1:0] edge_cnt;
  logic             sat;
  logic             at_max;
  logic             terminal;

  // s1/s2 synchronize the asynchronous input, s3 delays s2 for edge detection.
  assign rise     = s2 & ~s3;
  assign at_max   = (edge_cnt == CNT_MAX);
  assign terminal = (gate_cnt == GATE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      state          <= ST_IDLE;
      gate_cnt       <= '0;
      edge_cnt       <= '0;
      sat            <= 1'b0;
      bus.freq_hz    <= '0;
      bus.freq_valid <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      // The edge pipeline runs in every state, so s3 already tracks s2 when a
      // window opens and no stale edge is seen on entry.
      s1             <= bus.tick_in;
      s2             <= s1;
      s3             <= s2;
      bus.freq_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          // A rise during this transition cycle is intentionally dropped.
          if (bus.enable) begin
            state    <= ST_MEASURE;
            bus.busy <= 1'b1;
          end
        end

        ST_MEASURE: begin
          if (!bus.enable) begin
            // Abort: discard the partial window, keep the previous report.
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else if (terminal) begin
            // Fold the terminal-cycle rise into the closing window so the
            // next window starts clean and no edge straddles the boundary.
            bus.freq_hz    <= at_max ? CNT_MAX : edge_cnt + WIDTH'(rise);
            bus.overflow   <= sat | (rise & at_max);
            bus.freq_valid <= 1'b1;
            gate_cnt       <= '0;
            edge_cnt       <= '0;
            sat            <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            if (rise) begin
              // Saturation means an edge arrived that could not be counted.
              if (at_max) begin
                sat <= 1'b1;
              end else begin
                edge_cnt <= edge_cnt + WIDTH'(1);
              end
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
